// File: rtl/axi_rd_slave_responder_pkg.sv
// axi_rd_pkg: AR/R payload layout, BURST/RESP codes and responder FSM states
package axi_rd_pkg;
  localparam int AR_W = 49;
  localparam int R_W = 43;
  localparam int AR_ID_LSB = 41;
  localparam int AR_ADDR_LSB = 9;
  localparam int AR_LEN_LSB = 5;
  localparam int AR_BURST_LSB = 0;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {IDLE, RD, CAP, PUSH} state_e;
endpackage

// File: rtl/axi_rd_slave_responder_if.sv
// axi_rd_slave_responder_if: AR FIFO read side, R FIFO write side and SRAM pins; slave = responder, master = environment
interface axi_rd_slave_responder_if
  import axi_rd_pkg::*;
#(parameter int ADDR_W = 14);
  logic [AR_W-1:0] ar_rdata;
  logic ar_rempty;
  logic ar_rpop;
  logic [R_W-1:0] r_wdata;
  logic r_wpush;
  logic r_wfull;
  logic mem_ceb;
  logic mem_web;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0] mem_do;
  modport slave (input ar_rdata, ar_rempty, r_wfull, mem_do, output ar_rpop, r_wdata, r_wpush, mem_ceb, mem_web, mem_a);
  modport master (output ar_rdata, ar_rempty, r_wfull, mem_do, input ar_rpop, r_wdata, r_wpush, mem_ceb, mem_web, mem_a);
endinterface

// File: rtl/axi_rd_slave_responder_rd_burst_addr_gen.sv
// rd_burst_addr_gen: next beat address (INCR +4, otherwise held) and LAST flag from addr/burst/beat_cnt/len
module rd_burst_addr_gen
  import axi_rd_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [1:0]  burst,
  input  logic [3:0]  beat_cnt,
  input  logic [3:0]  len,
  output logic [31:0] next_addr,
  output logic        last
);
  assign next_addr = (burst == BURST_INCR) ? addr + 32'd4 : addr;
  assign last = beat_cnt == len;
endmodule

// File: rtl/axi_rd_slave_responder.sv
// axi_rd_slave_responder: pops AR requests, reads bursts from a 1-cycle SRAM, pushes R beats (clk, rst, bus: slave modport); ADDR_RANGE_CHECK_EN enables DECERR on out-of-range start address
module axi_rd_slave_responder
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int ID_W = 8
) (
  input logic clk,
  input logic rst,
  axi_rd_slave_responder_if.slave bus
);
  state_e state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, next_addr, ar_addr;
  logic [3:0] len_q, len_d, cnt_q, cnt_d;
  logic [1:0] burst_q, burst_d, resp_q, resp_d, ar_burst, ar_resp;
  logic last, range_err;
  assign ar_addr = bus.ar_rdata[AR_ADDR_LSB +: 32];
  assign ar_burst = bus.ar_rdata[AR_BURST_LSB +: 2];
`ifdef ADDR_RANGE_CHECK_EN
  assign range_err = |ar_addr[31:ADDR_W+2];
`else
  assign range_err = 1'b0;
`endif
  // error bursts never touch the SRAM; their RESP is fixed for the whole burst at capture
  assign ar_resp = range_err ? RESP_DECERR : (ar_burst >= BURST_WRAP) ? RESP_SLVERR : RESP_OKAY;
  rd_burst_addr_gen u_gen (
    .addr(addr_q),
    .burst(burst_q),
    .beat_cnt(cnt_q),
    .len(len_q),
    .next_addr(next_addr),
    .last(last)
  );
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    addr_d = addr_q;
    len_d = len_q;
    burst_d = burst_q;
    cnt_d = cnt_q;
    data_d = data_q;
    resp_d = resp_q;
    unique case (state_q)
      IDLE: if (!bus.ar_rempty) begin
        id_d = bus.ar_rdata[AR_ID_LSB +: ID_W];
        addr_d = ar_addr;
        len_d = bus.ar_rdata[AR_LEN_LSB +: 4];
        burst_d = ar_burst;
        cnt_d = '0;
        data_d = '0;
        resp_d = ar_resp;
        state_d = (ar_resp == RESP_OKAY) ? RD : PUSH;
      end
      RD: state_d = CAP;
      CAP: begin
        data_d = bus.mem_do;
        state_d = PUSH;
      end
      PUSH: if (!bus.r_wfull) begin
        cnt_d = last ? cnt_q : cnt_q + 4'd1;
        addr_d = last ? addr_q : next_addr;
        state_d = last ? IDLE : (resp_q == RESP_OKAY) ? RD : PUSH;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      burst_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      addr_q <= addr_d;
      len_q <= len_d;
      burst_q <= burst_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      resp_q <= resp_d;
    end
  end
  assign bus.ar_rpop = (state_q == IDLE) && !bus.ar_rempty && !rst;
  assign bus.r_wpush = (state_q == PUSH) && !bus.r_wfull && !rst;
  assign bus.r_wdata = (state_q == PUSH) ? {id_q, data_q, resp_q, last} : '0;
  assign bus.mem_ceb = state_q != RD;
  assign bus.mem_web = 1'b1;
  assign bus.mem_a = addr_q[ADDR_W+1:2];
endmodule

// File: tb/tb_axi_rd_slave_responder.sv
// tb_axi_rd_slave_responder: scoreboard bench with AR FIFO and SRAM models around axi_rd_slave_responder
module tb_axi_rd_slave_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int issued = 0;
  int pops = 0;
  logic [48:0] ar_q[$];
  logic [42:0] exp_r[$];
  logic [13:0] exp_a[$];
  logic [31:0] mem [0:16383];
  logic pop_n = 1'b0;
  logic rd_n = 1'b0;
  logic [13:0] a_n = '0;
  logic [31:0] mem_do_n = '0;
  always #5 clk = ~clk;
  axi_rd_slave_responder_if #(.ADDR_W(14)) bif ();
  axi_rd_slave_responder #(.ADDR_W(14), .ID_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bif));
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    logic [31:0] a;
    logic ok;
    a = addr;
    ok = !burst[1];
    ar_q.push_back({id, addr, len, 3'b010, burst});
    issued++;
    for (int i = 0; i <= int'(len); i++) begin
      if (ok) exp_a.push_back(a[15:2]);
      exp_r.push_back({id, ok ? mem[a[15:2]] : 32'h0, ok ? 2'b00 : 2'b10, i == int'(len)});
      if (burst == 2'b01) a += 32'd4;
    end
  endtask
  task automatic wait_push(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bif.r_wpush !== 1'b1 && n < 50);
    if (bif.r_wpush !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: no push within 50 cycles", name);
    end
  endtask
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_r.size() != 0 || ar_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s: drain timeout, %0d beats still expected", name, exp_r.size());
    end
    repeat (2) @(negedge clk);
  endtask
  always @(posedge clk) begin
    if (pop_n && ar_q.size() != 0) void'(ar_q.pop_front());
    if (rd_n) mem_do_n = mem[a_n];
    #1;
    bif.ar_rempty = ar_q.size() == 0;
    bif.ar_rdata = (ar_q.size() != 0) ? ar_q[0] : '0;
    bif.mem_do = mem_do_n;
  end
  always @(negedge clk) begin
    pop_n = bif.ar_rpop === 1'b1;
    rd_n = bif.mem_ceb === 1'b0;
    a_n = bif.mem_a;
    if (!rst) begin
      if (bif.ar_rpop === 1'b1) begin
        pops++;
        check("pop_while_empty", {63'd0, bif.ar_rempty}, 64'd0);
        check("pop_with_push", {63'd0, bif.r_wpush}, 64'd0);
      end
      if (bif.r_wpush === 1'b1) begin
        if (exp_r.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_beat_unexpected: got %h expected none", bif.r_wdata);
        end else check("r_beat", {21'd0, bif.r_wdata}, {21'd0, exp_r.pop_front()});
      end
      if (bif.mem_ceb === 1'b0) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sram_read_unexpected: got mem_a %0d expected no access", bif.mem_a);
        end else check("mem_a", {50'd0, bif.mem_a}, {50'd0, exp_a.pop_front()});
      end
    end
  end
  initial begin
    int n;
    bif.r_wfull = 1'b0;
    mem[16] = 32'hDEAD_BEEF;
    mem[64] = 32'h1111_0001;
    mem[65] = 32'h2222_0002;
    mem[66] = 32'h3333_0003;
    mem[67] = 32'h4444_0004;
    mem[8] = 32'hCAFE_F00D;
    mem[128] = 32'hA5A5_0128;
    mem[129] = 32'h5A5A_0129;
    mem[256] = 32'h0BAD_0100;
    mem[257] = 32'h0BAD_0101;
    mem[258] = 32'h0BAD_0102;
    mem[259] = 32'h0BAD_0103;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ar_rpop", {63'd0, bif.ar_rpop}, 64'd0);
    check("rst_r_wpush", {63'd0, bif.r_wpush}, 64'd0);
    check("rst_r_wdata", {21'd0, bif.r_wdata}, 64'd0);
    check("rst_mem_ceb", {63'd0, bif.mem_ceb}, 64'd1);
    check("rst_mem_web", {63'd0, bif.mem_web}, 64'd1);
    check("rst_mem_a", {50'd0, bif.mem_a}, 64'd0);
    run_ar(8'h12, 32'h0000_0040, 4'd0, 2'b01);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bif.ar_rpop !== 1'b1 && n < 20);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bif.r_wpush !== 1'b1 && n < 20);
    check("first_beat_latency", 64'(n), 64'd3);
    drain("single");
    run_ar(8'h21, 32'h0000_0100, 4'd3, 2'b01);
    drain("incr");
    run_ar(8'h34, 32'h0000_0020, 4'd2, 2'b00);
    drain("fixed");
    run_ar(8'h56, 32'h0000_0200, 4'd1, 2'b01);
    wait_push("bp_beat0");
    @(posedge clk);
    #1 bif.r_wfull = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_no_push", {63'd0, bif.r_wpush}, 64'd0);
      check("bp_wdata_hold", {21'd0, bif.r_wdata}, {21'd0, 8'h56, 32'h5A5A_0129, 2'b00, 1'b1});
    end
    @(posedge clk);
    #1 bif.r_wfull = 1'b0;
    drain("backpressure");
    run_ar(8'h78, 32'h0000_0300, 4'd1, 2'b10);
    drain("wrap");
    run_ar(8'h79, 32'h0000_0304, 4'd0, 2'b11);
    drain("reserved");
    ar_q.push_back({8'h9A, 32'h0000_0400, 4'd3, 3'b010, 2'b01});
    issued++;
    exp_a.push_back(14'd256);
    exp_a.push_back(14'd257);
    exp_a.push_back(14'd258);
    exp_r.push_back({8'h9A, 32'h0BAD_0100, 2'b00, 1'b0});
    exp_r.push_back({8'h9A, 32'h0BAD_0101, 2'b00, 1'b0});
    run_ar(8'h77, 32'h0000_0040, 4'd0, 2'b01);
    wait_push("rst_beat0");
    wait_push("rst_beat1");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_ar_rpop", {63'd0, bif.ar_rpop}, 64'd0);
    check("midrst_r_wpush", {63'd0, bif.r_wpush}, 64'd0);
    check("midrst_r_wdata", {21'd0, bif.r_wdata}, 64'd0);
    check("midrst_mem_ceb", {63'd0, bif.mem_ceb}, 64'd1);
    check("midrst_mem_a", {50'd0, bif.mem_a}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drain("after_reset");
    check("exp_r_empty", 64'(exp_r.size()), 64'd0);
    check("exp_a_empty", 64'(exp_a.size()), 64'd0);
    check("ar_pop_count", 64'(pops), 64'(issued));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_rd_slave_responder.md
Name: axi_rd_slave_responder

Overview:
Slave-clock-domain consumer of the AR channel async FIFO and producer for the R channel async FIFO.
- Pops one 49-bit AR request and runs the burst against a single-port SRAM with 1-cycle read latency.
- Pushes one 43-bit R beat per burst beat into the R FIFO, honouring the FIFO's full flag.
- Sits between the slave side of the AR/R FIFO pair and the slave memory macro.

Parameters:
ADDR_W, 14, SRAM word-address width; the byte address maps as mem_a = addr[ADDR_W+1:2].
ID_W, 8, AXI ID width; must match the package AR/R layout.

Ports:
clk  in  1  slave-domain clock
rst  in  1  synchronous, active-high reset
ar_rdata  in  49  AR FIFO head, valid while ar_rempty=0; fields {ID[48:41], ADDR[40:9], LEN[8:5], SIZE[4:2], BURST[1:0]}
ar_rempty  in  1  AR FIFO empty
ar_rpop  out  1  pop AR FIFO head; asserted only when ar_rempty=0
r_wdata  out  43  R beat {ID[42:35], DATA[34:3], RESP[2:1], LAST[0]}
r_wpush  out  1  push R beat; asserted only when r_wfull=0
r_wfull  in  1  R FIFO full
mem_ceb  out  1  SRAM chip enable, active low
mem_web  out  1  SRAM write enable, active low; held at 1
mem_a  out  ADDR_W  SRAM word address
mem_do  in  32  SRAM read data, valid the cycle after mem_ceb=0

Behaviour:
- Reset (sync, active-high): state=IDLE; ar_rpop=0, r_wpush=0, r_wdata=0, mem_ceb=1, mem_web=1, mem_a=0; internal beat counter, address and data registers cleared.
- FSM has four states: IDLE, RD, CAP, PUSH.
- IDLE:
  - If ar_rempty=0, capture ID/ADDR/LEN/BURST from ar_rdata and drive ar_rpop=1 for exactly that cycle.
  - Set beat_cnt=0 and go to RD.
  - SIZE is ignored; all beats are 32-bit.
- RD: drive mem_ceb=0 and mem_a=addr[ADDR_W+1:2] for one cycle, then go to CAP.
- CAP: latch mem_do into the data register, then go to PUSH.
- PUSH:
  - r_wpush = ~r_wfull; r_wdata = {ID, data, RESP, LAST}.
  - LAST = (beat_cnt == LEN).
  - While r_wfull=1, hold r_wdata and the data register stable and wait.
  - On a push with LAST=1, go to IDLE.
  - Otherwise increment beat_cnt, advance the address and go to RD.
- Address advance depends on BURST:
  - INCR (2'b01): addr += 4. Wraps modulo 2^32; no 4KB check.
  - FIXED (2'b00): addr is unchanged.
  - WRAP and reserved (2'b10, 2'b11): no SRAM access. RD and CAP are skipped and data=0. Every beat returns RESP=SLVERR (2'b10) and all LEN+1 beats are still returned.
- Normal RESP=OKAY (2'b00).
- Latency:
  - AR visible at cycle 0, pop at cycle 0, SRAM read at cycle 1, capture at cycle 2, first push at cycle 3 if not full.
  - Steady state is 3 cycles per beat.
- ar_rpop and r_wpush are never asserted in the same cycle. There is no new AR pop until the LAST beat has been pushed.
- Reset mid-burst: the burst is abandoned immediately and no further beats are pushed. Beats already in the R FIFO are not recalled.

Optional Feature:
ADDR_RANGE_CHECK_EN
- Defined:
  - If ADDR[31:ADDR_W+2] != 0 at capture, the whole burst returns RESP=DECERR (2'b11) with data=0 and no SRAM access.
  - The check uses the start address only.
- Undefined: upper address bits are ignored, so accesses alias into SRAM.

Decomposition:
- Package axi_rd_pkg holds:
  - AR/R payload widths (49, 43) and field bit offsets.
  - BURST codes FIXED/INCR/WRAP.
  - RESP codes OKAY/SLVERR/DECERR.
  - The FSM state enum {IDLE, RD, CAP, PUSH}.
- One natural sub-module is rd_burst_addr_gen: a combinational next-address and LAST generator from addr, BURST, beat_cnt and LEN.

Test Plan:
- Single beat: AR {ID=8'h12, ADDR=32'h0000_0040, LEN=0, BURST=INCR}, SRAM[16]=32'hDEAD_BEEF -> one push at cycle 3 with r_wdata={8'h12, 32'hDEAD_BEEF, 2'b00, 1'b1}; one ar_rpop pulse.
- INCR burst LEN=3 from 32'h100 -> mem_a 64, 65, 66, 67; four beats with LAST only on the 4th and RESP=OKAY.
- FIXED burst LEN=2 at 32'h20 -> mem_a=8 on all three reads; three identical-address beats.
- Backpressure: r_wfull=1 for 5 cycles during beat 1 of LEN=1 -> r_wpush stays 0 and r_wdata is stable; push on the first cycle r_wfull=0, and no beat is lost or duplicated.
- WRAP burst LEN=1 -> mem_ceb stays 1; two beats with data=0, RESP=2'b10, LAST on the 2nd.
- rst asserted at the CAP state of beat 2 of a LEN=3 burst -> next cycle all outputs are at reset values; with the next AR queued, a fresh burst starts correctly.
